// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
//   Writer side of the 4 KB instruction memory. Receives a byte stream over a
//   valid/ready handshake, assembles four bytes per 32-bit word in big-endian
//   (MIPS) order and writes words 0..len-1 through the IM write port. The CPU
//   is held in reset for the whole load; a one-cycle done pulse marks the end.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle load request, only honoured while idle
//   len        : number of words to load (1..MAX_WORDS), sampled with start
//   byte_valid : byte_data carries a valid byte
//   byte_data  : incoming byte
//   byte_ready : loader takes a byte this cycle (transfer = valid & ready)
//   im_we      : IM write enable, one pulse per assembled word
//   im_addr    : IM word address (byte address bits [11:2])
//   im_din     : IM write data
//   busy       : load in progress (receiving or writing)
//   cpu_hold   : keep CPU in reset, from accepted start through the done cycle
//   done       : one-cycle pulse after the last word is written
//   err        : sticky flag, last start carried an illegal len
// -----------------------------------------------------------------------------
module im_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_din,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // len is one bit wider than the address so MAX_WORDS itself fits.
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(MAX_WORDS);
    localparam logic [ADDR_W:0] ONE_LEN = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic              byte_ready_q, byte_ready_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_din_q, im_din_d;
    logic              busy_q, busy_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    // Only the first three bytes need storing; the fourth goes straight to im_din.
    logic [23:0]       word_q, word_d;

    logic              len_ok;
    logic              xfer;
    logic              last_word;
    logic [ADDR_W:0]   len_m1;

    assign len_ok    = (len != '0) && (len <= MAX_LEN);
    assign xfer      = byte_valid && byte_ready_q;
    assign len_m1    = len_q - ONE_LEN;
    assign last_word = ({1'b0, cnt_q} == len_m1);

    always_comb begin
        state_d      = state_q;
        byte_ready_d = byte_ready_q;
        im_we_d      = 1'b0;
        im_addr_d    = im_addr_q;
        im_din_d     = im_din_q;
        busy_d       = busy_q;
        cpu_hold_d   = cpu_hold_q;
        done_d       = 1'b0;
        err_d        = err_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        word_d       = word_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        len_d        = len;
                        cnt_d        = '0;
                        idx_d        = '0;
                        err_d        = 1'b0;
                        busy_d       = 1'b1;
                        cpu_hold_d   = 1'b1;
                        byte_ready_d = 1'b1;
                        state_d      = RECV;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            RECV: begin
                if (xfer) begin
                    word_d = {word_q[15:0], byte_data};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // Fourth byte: word is complete, write it next cycle.
                        byte_ready_d = 1'b0;
                        im_we_d      = 1'b1;
                        im_addr_d    = cnt_q;
                        im_din_d     = {word_q, byte_data};
                        state_d      = WRITE;
                    end
                end
            end

            WRITE: begin
                if (last_word) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d        = cnt_q + 1'b1;
                    idx_d        = '0;
                    byte_ready_d = 1'b1;
                    state_d      = RECV;
                end
            end

            DONE: begin
                cpu_hold_d = 1'b0;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            byte_ready_q <= 1'b0;
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            im_din_q     <= '0;
            busy_q       <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            len_q        <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            word_q       <= '0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= byte_ready_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            im_din_q     <= im_din_d;
            busy_q       <= busy_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign im_we      = im_we_q;
    assign im_addr    = im_addr_q;
    assign im_din     = im_din_q;
    assign busy       = busy_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_im_loader.sv
// -----------------------------------------------------------------------------
// tb_im_loader
//   Self-checking bench for im_loader. Each load pushes the expected
//   (address, word) pairs, built from the byte list in big-endian order, into a
//   queue; a monitor pops one entry per im_we pulse and compares.
// -----------------------------------------------------------------------------
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] len = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        im_we;
    logic [9:0]  im_addr;
    logic [31:0] im_din;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        err;

    im_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_din     (im_din),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          we_cnt  = 0;
    int          done_cnt = 0;
    logic [7:0]  stim[$];
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Write monitor: every im_we pulse must match the next expected word.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n) begin
            if (im_we) begin
                we_cnt++;
                if (exp_q.size() == 0) begin
                    chk("extra_we", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("we_addr", 64'(im_addr), 64'(e[41:32]));
                    chk("we_data", 64'(im_din), 64'(e[31:0]));
                end
                if (!busy) chk("busy_in_write", 64'(busy), 64'd1);
            end
            if (done) done_cnt++;
            if (byte_ready && (im_we || done)) chk("ready_in_write_done", 64'd1, 64'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int tmo;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        tmo = 0;
        while (!byte_ready && tmo < 50) begin
            @(negedge clk);
            tmo++;
        end
        if (tmo >= 50) chk("ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Loads n words taken from stim; restart_word >= 0 pulses a stray start
    // (with illegal len) just before that word.
    task automatic load(input int n, input int maxgap, input int restart_word);
        int tmo;
        for (int w = 0; w < n; w++)
            exp_q.push_back({22'd0, 10'(w), stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3]});
        @(negedge clk);
        start = 1'b1;
        len   = 11'(n);
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_hold", 64'(cpu_hold), 64'd1);
        chk("start_err", 64'(err), 64'd0);
        for (int w = 0; w < n; w++) begin
            if (w == restart_word) begin
                start = 1'b1;
                len   = 11'd0;
                @(negedge clk);
                start = 1'b0;
                chk("restart_err", 64'(err), 64'd0);
                chk("restart_busy", 64'(busy), 64'd1);
            end
            for (int b = 0; b < 4; b++)
                send_byte(stim[4*w+b], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
            chk("we_latency", 64'(im_we), 64'd1);
        end
        tmo = 0;
        while (!done && tmo < 10) begin
            @(negedge clk);
            tmo++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("done_hold", 64'(cpu_hold), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("after_done", 64'(done), 64'd0);
        chk("hold_drop", 64'(cpu_hold), 64'd0);
        chk("exp_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int we0, dn0, n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", {byte_ready, im_we, im_addr, im_din, busy, cpu_hold, done, err}, 64'd0);
        rst_n = 1'b1;

        // Two words back-to-back, then with random stalls
        stim = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        load(2, 0, -1);
        load(2, 5, -1);

        // Illegal lengths
        we0 = we_cnt;
        @(negedge clk);
        start = 1'b1; len = 11'd0;
        @(negedge clk);
        start = 1'b0;
        chk("len0_err", 64'(err), 64'd1);
        chk("len0_busy", 64'(busy), 64'd0);
        chk("len0_hold", 64'(cpu_hold), 64'd0);
        start = 1'b1; len = 11'd1025;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("len1025_err", 64'(err), 64'd1);
        chk("len1025_busy", 64'(busy), 64'd0);
        chk("illegal_no_we", 64'(we_cnt - we0), 64'd0);
        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        load(1, 0, -1);
        chk("legal_clears_err", 64'(err), 64'd0);

        // Asynchronous reset mid-cycle after two bytes of word 0
        we0 = we_cnt;
        @(negedge clk);
        start = 1'b1; len = 11'd1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {byte_ready, im_we, im_addr, im_din, busy, cpu_hold, done, err}, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("partial_no_we", 64'(we_cnt - we0), 64'd0);
        stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        load(1, 0, -1);
        chk("after_rst_count", 64'(we_cnt - we0), 64'd1);

        // Random loads
        for (int k = 0; k < 4; k++) begin
            n = int'($urandom_range(6, 1));
            stim.delete();
            for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
            load(n, 3, -1);
        end

        // Full-size load with a stray start in the middle
        stim.delete();
        for (int i = 0; i < 4096; i++) stim.push_back(8'(i));
        we0 = we_cnt;
        dn0 = done_cnt;
        load(1024, 0, 100);
        chk("full_we_count", 64'(we_cnt - we0), 64'd1024);
        chk("full_done_count", 64'(done_cnt - dn0), 64'd1);
        chk("full_last_addr", 64'(im_addr), 64'h3FF);
        chk("full_last_data", 64'(im_din), 64'hFCFDFEFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
